// File: rtl/decomp_mul_seq_if.sv
// rtl/decomp_mul_seq_if.sv - operand/result handshake and shared-multiplier bundle
interface decomp_mul_seq_if #(
    parameter int WIDTH = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2*WIDTH-1:0]     in_a;
    logic [2*WIDTH-1:0]     in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*WIDTH-1:0]     out_r;
    logic                   busy;
    logic [WIDTH-1:0]       mul_a;
    logic [WIDTH-1:0]       mul_b;
    logic [2*WIDTH-1:0]     mul_r;

    // Producer/consumer side, which also hosts the W x W multiplier
    modport master (
        output in_valid, in_a, in_b, out_ready, mul_r,
        input  in_ready, out_valid, out_r, busy, mul_a, mul_b
    );

    // Controller side
    modport slave (
        input  in_valid, in_a, in_b, out_ready, mul_r,
        output in_ready, out_valid, out_r, busy, mul_a, mul_b
    );
endinterface

// File: rtl/decomp_mul_seq.sv
// rtl/decomp_mul_seq.sv - 2W x 2W product built from one time-shared W x W multiplier
module decomp_mul_seq #(
    parameter int WIDTH       = 4,
    parameter int SKIP_LL     = 0,
    parameter int ZERO_BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    decomp_mul_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PASS, DONE} state_t;

    state_t                 state;
    state_t                 state_next;

    logic [WIDTH-1:0]       a_h;
    logic [WIDTH-1:0]       a_l;
    logic [WIDTH-1:0]       b_h;
    logic [WIDTH-1:0]       b_l;
    logic [4*WIDTH-1:0]     acc;
    logic [4*WIDTH-1:0]     out_r_q;
    logic [1:0]             cnt;

    logic                   accept;
    logic                   last_pass;
    logic                   zero_hit;
    logic                   in_ready_c;
    logic                   out_valid_c;
    logic                   busy_c;
    logic [WIDTH-1:0]       mul_a_c;
    logic [WIDTH-1:0]       mul_b_c;
    logic [4*WIDTH-1:0]     prod_ext;
    logic [4*WIDTH-1:0]     term;

    // A zero operand short-circuits every pass when bypass is enabled
    assign zero_hit = (ZERO_BYPASS != 0) &&
                      ((bus.in_a == '0) || (bus.in_b == '0));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake outputs and per-pass operand selection
    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b1;
        mul_a_c     = '0;
        mul_b_c     = '0;
        accept      = 1'b0;
        last_pass   = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b0;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = zero_hit ? DONE : PASS;
                end
            end
            PASS: begin
                case (cnt)
                    2'd0: begin mul_a_c = a_l; mul_b_c = b_l; end
                    2'd1: begin mul_a_c = a_l; mul_b_c = b_h; end
                    2'd2: begin mul_a_c = a_h; mul_b_c = b_l; end
                    default: begin mul_a_c = a_h; mul_b_c = b_h; end
                endcase
                if (cnt == 2'd3) begin
                    last_pass  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Align the current partial product: LL at 0, cross terms at W, HH at 2W
    always_comb begin
        prod_ext = {{(2*WIDTH){1'b0}}, bus.mul_r};
        case (cnt)
            2'd0:    term = prod_ext;
            2'd3:    term = prod_ext << (2*WIDTH);
            default: term = prod_ext << WIDTH;
        endcase
    end

    // Operand capture, accumulation and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            a_h     <= '0;
            a_l     <= '0;
            b_h     <= '0;
            b_l     <= '0;
            acc     <= '0;
            cnt     <= 2'd0;
            out_r_q <= '0;
        end else if (accept) begin
            a_h <= bus.in_a[2*WIDTH-1:WIDTH];
            a_l <= bus.in_a[WIDTH-1:0];
            b_h <= bus.in_b[2*WIDTH-1:WIDTH];
            b_l <= bus.in_b[WIDTH-1:0];
            acc <= '0;
            cnt <= (SKIP_LL != 0) ? 2'd1 : 2'd0;
            if (zero_hit) begin
                out_r_q <= '0;
            end
        end else if (state == PASS) begin
            acc <= acc + term;
            cnt <= cnt + 2'd1;
            if (last_pass) begin
                out_r_q <= acc + term;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.mul_a     = mul_a_c;
    assign bus.mul_b     = mul_b_c;
    assign bus.out_r     = out_r_q;
endmodule

// File: tb/tb_decomp_mul_seq.sv
// tb/tb_decomp_mul_seq.sv - self-checking bench for decomp_mul_seq
module tb_decomp_mul_seq;
    localparam int W = 4;

    logic clk;
    logic rst;

    decomp_mul_seq_if #(.WIDTH(W)) bus0 ();
    decomp_mul_seq_if #(.WIDTH(W)) bus1 ();

    decomp_mul_seq #(.WIDTH(W), .SKIP_LL(0), .ZERO_BYPASS(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    decomp_mul_seq #(.WIDTH(W), .SKIP_LL(1), .ZERO_BYPASS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Exact W x W multipliers shared by each controller
    assign bus0.mul_r = {4'b0, bus0.mul_a} * {4'b0, bus0.mul_b};
    assign bus1.mul_r = {4'b0, bus1.mul_a} * {4'b0, bus1.mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    logic [15:0] sb[$];
    logic [7:0]  seq_log[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard pop on every consumed result; mul ports idle outside PASS
    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.out_valid && bus0.out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_output", 32'(bus0.out_r), 32'hFFFF_FFFF);
                end else begin
                    chk("sb_out_r", 32'(bus0.out_r), 32'(sb.pop_front()));
                    n_out++;
                end
            end
            if (!bus0.busy || bus0.out_valid) begin
                chk("mul_idle_zero", {24'd0, bus0.mul_a, bus0.mul_b}, 32'd0);
            end
        end
    end

    // One transaction on dut0 with out_ready held high
    task automatic do_txn(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] expv, input int exp_lat);
        int guard;
        int lat;
        bus0.in_a      = a;
        bus0.in_b      = b;
        bus0.in_valid  = 1'b1;
        bus0.out_ready = 1'b1;
        guard = 0;
        while (!bus0.in_ready && guard < 50) begin
            tick;
            guard++;
        end
        chk("accept_ready", {31'd0, bus0.in_ready}, 32'd1);
        sb.push_back(expv);
        tick;
        bus0.in_valid = 1'b0;
        bus0.in_a     = 8'($urandom);
        bus0.in_b     = 8'($urandom);
        seq_log.delete();
        lat = 1;
        while (!bus0.out_valid && lat < 20) begin
            seq_log.push_back({bus0.mul_a, bus0.mul_b});
            tick;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("out_r", 32'(bus0.out_r), 32'(expv));
        tick;
    endtask

    task automatic drain;
        int guard;
        guard = 0;
        while ((sb.size() != 0 || bus0.busy) && guard < 100) begin
            tick;
            guard++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int guard;
        int lat;
        int accepted;
        int base;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] exp_seq0[4];
        logic [7:0] exp_seq1[3];

        vecs[0] = '{8'hB7, 8'h5C, 16'h41C4, 5};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 5};
        vecs[2] = '{8'h00, 8'h9F, 16'h0000, 1};
        vecs[3] = '{8'h9F, 8'h00, 16'h0000, 1};
        vecs[4] = '{8'h03, 8'h05, 16'h000F, 5};
        vecs[5] = '{8'h01, 8'h01, 16'h0001, 5};
        vecs[6] = '{8'h80, 8'h80, 16'h4000, 5};
        exp_seq0 = '{8'h7C, 8'h75, 8'hBC, 8'hB5};
        exp_seq1 = '{8'h75, 8'hBC, 8'hB5};

        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.out_ready = 1'b0;
        tick;
        tick;
        chk("rst_in_ready", {31'd0, bus0.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus0.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus0.busy}, 32'd0);
        chk("rst_out_r", 32'(bus0.out_r), 32'd0);
        chk("rst_mul", {24'd0, bus0.mul_a, bus0.mul_b}, 32'd0);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat);
            if (i == 0) begin
                chk("seq_len", 32'(seq_log.size()), 32'd4);
                for (int k = 0; k < 4 && k < seq_log.size(); k++) begin
                    chk("mul_seq", 32'(seq_log[k]), 32'(exp_seq0[k]));
                end
            end
        end
        drain;

        // SKIP_LL=1 controller: three passes starting at a_l x b_h
        bus1.out_ready = 1'b1;
        bus1.in_a = 8'hB7;
        bus1.in_b = 8'h5C;
        bus1.in_valid = 1'b1;
        chk("skip_ready", {31'd0, bus1.in_ready}, 32'd1);
        tick;
        bus1.in_valid = 1'b0;
        seq_log.delete();
        lat = 1;
        while (!bus1.out_valid && lat < 20) begin
            seq_log.push_back({bus1.mul_a, bus1.mul_b});
            tick;
            lat++;
        end
        chk("skip_latency", 32'(lat), 32'd4);
        chk("skip_out_r", 32'(bus1.out_r), 32'h4170);
        chk("skip_seq_len", 32'(seq_log.size()), 32'd3);
        for (int k = 0; k < 3 && k < seq_log.size(); k++) begin
            chk("skip_mul_seq", 32'(seq_log[k]), 32'(exp_seq1[k]));
        end
        tick;
        chk("skip_idle", {31'd0, bus1.busy}, 32'd0);

        // Backpressure with a pending second pair
        bus0.out_ready = 1'b0;
        bus0.in_a = 8'h12;
        bus0.in_b = 8'h34;
        bus0.in_valid = 1'b1;
        chk("bp_ready", {31'd0, bus0.in_ready}, 32'd1);
        sb.push_back(16'h03A8);
        tick;
        bus0.in_a = 8'h21;
        bus0.in_b = 8'h43;
        guard = 0;
        while (!bus0.out_valid && guard < 20) begin
            tick;
            guard++;
        end
        for (int k = 0; k < 3; k++) begin
            chk("bp_out_valid", {31'd0, bus0.out_valid}, 32'd1);
            chk("bp_out_r", 32'(bus0.out_r), 32'h03A8);
            chk("bp_in_ready", {31'd0, bus0.in_ready}, 32'd0);
            tick;
        end
        bus0.out_ready = 1'b1;
        tick;
        chk("bp_back_idle", {31'd0, bus0.in_ready}, 32'd1);
        sb.push_back(16'h08A3);
        tick;
        bus0.in_valid = 1'b0;
        drain;
        chk("bp_outputs", 32'(n_out), 32'd9);

        // Reset during pass p2 aborts the transaction
        bus0.in_a = 8'hB7;
        bus0.in_b = 8'h5C;
        bus0.in_valid = 1'b1;
        tick;
        bus0.in_valid = 1'b0;
        tick;
        tick;
        chk("abort_p2_mul", {24'd0, bus0.mul_a, bus0.mul_b}, 32'h0000_00BC);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_busy", {31'd0, bus0.busy}, 32'd0);
        chk("abort_out_valid", {31'd0, bus0.out_valid}, 32'd0);
        chk("abort_out_r", 32'(bus0.out_r), 32'd0);
        chk("abort_in_ready", {31'd0, bus0.in_ready}, 32'd1);
        do_txn(8'h03, 8'h05, 16'h000F, 5);
        drain;

        // Back-to-back random pairs with in_valid held high
        base = n_out;
        accepted = 0;
        guard = 0;
        bus0.out_ready = 1'b1;
        ra = 8'($urandom);
        rb = 8'($urandom);
        bus0.in_a = ra;
        bus0.in_b = rb;
        bus0.in_valid = 1'b1;
        while (accepted < 10 && guard < 500) begin
            if (bus0.in_ready) begin
                sb.push_back(16'(ra) * 16'(rb));
                accepted++;
                tick;
                ra = 8'($urandom);
                rb = 8'($urandom);
                bus0.in_a = ra;
                bus0.in_b = rb;
            end else begin
                tick;
            end
            guard++;
        end
        bus0.in_valid = 1'b0;
        chk("b2b_accepted", 32'(accepted), 32'd10);
        drain;
        chk("b2b_outputs", 32'(n_out - base), 32'd10);

        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decomp_mul_seq.md
Name: decomp_mul_seq

Overview:
- Sequential controller that computes an unsigned 2W x 2W product by time-multiplexing one external W x W multiplier. The multiplier may be approximate (EIM-class) or exact.
- Splits the operands into W-bit halves, drives one sub-multiplication per cycle, then shifts and accumulates the partial products.
- Sits between the PE operand registers and a shared small multiplier. It lets a wide MAC reuse the approximate 4x4 cores.
- The multiplier interface is exposed as ports, so the block is multiplier-agnostic.

Parameters:
- WIDTH, 4, sub-multiplier operand width W. Operands are 2W bits; the result is 4W bits.
- SKIP_LL, 0, when 1 the low x low partial product is omitted (approximation mode): 3 passes instead of 4.
- ZERO_BYPASS, 1, when 1 a zero operand skips all passes and produces result 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- in_a  in  2*WIDTH  multiplicand, unsigned.
- in_b  in  2*WIDTH  multiplier, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_r  out  4*WIDTH  product.
- busy  out  1  high in any state except IDLE.
- mul_a  out  WIDTH  operand A to the shared W x W multiplier.
- mul_b  out  WIDTH  operand B to the shared W x W multiplier.
- mul_r  in  2*WIDTH  combinational product returned by the multiplier.

Behaviour:
- Reset: the following hold while rst=1 at a clock edge and after it:
  - state=IDLE
  - in_ready=1, out_valid=0, busy=0
  - out_r=0, accumulator=0, pass counter=0
  - mul_a=0, mul_b=0
- Reset during any state aborts the transaction. No output is produced for it.
- States: IDLE, PASS, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready the block latches a_h, a_l, b_h, b_l and clears the accumulator.
  - If ZERO_BYPASS=1 and (in_a==0 or in_b==0), next state is DONE with out_r=0.
  - Otherwise next state is PASS, with the counter set to 1 if SKIP_LL=1, else 0.
- PASS:
  - in_ready=0.
  - mul_a/mul_b are driven combinationally from the counter:
    - p0 = a_l x b_l, shift 0.
    - p1 = a_l x b_h, shift W.
    - p2 = a_h x b_l, shift W.
    - p3 = a_h x b_h, shift 2W.
  - At each edge: acc <= acc + (zero-extend(mul_r) << shift), then counter increments.
  - After p3 accumulates, out_r <= final acc and next state is DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - out_r is held stable until out_valid&&out_ready. On that edge next state is IDLE and out_valid drops.
  - out_ready is ignored in every other state.
- mul_a/mul_b are 0 outside PASS. mul_r is sampled only in PASS.
- Latency, counted from the accepting edge to the first cycle with out_valid=1 (out_ready held high):
  - 5 cycles with SKIP_LL=0.
  - 4 cycles with SKIP_LL=1.
  - 1 cycle on zero bypass.
- Throughput: one transaction per latency+1 cycles. No overlap, and no new accept in the same cycle that DONE is consumed.
- Arithmetic:
  - The accumulator is 4W bits wide and cannot overflow with an exact multiplier (max (2^2W-1)^2).
  - With an approximate multiplier the sum wraps modulo 2^4W. No saturation is applied.
- in_a/in_b changes after acceptance have no effect, because the operands are latched.

Test Plan:
- W=4, exact multiplier, SKIP_LL=0: in_a=0xB7, in_b=0x5C, out_ready=1.
  - mul_a/mul_b sequence is (7,12), (7,5), (11,12), (11,5).
  - out_r=0x41C4 (16836), with out_valid 5 cycles after accept.
- Same operands with SKIP_LL=1: 3 passes, starting at (7,5). out_r=0x4170 (16752), latency 4.
- in_a=0xFF, in_b=0xFF: out_r=0xFE01. Separately, in_a=0x00, in_b=0x9F with ZERO_BYPASS=1: out_r=0 one cycle after accept, mul_a=mul_b=0 throughout.
- Backpressure: 0x12 x 0x34 with out_ready=0 for 3 cycles after out_valid rises.
  - out_r holds 0x03A8, in_ready stays 0, and a pending in_valid is not accepted.
  - After out_ready=1 the block returns to IDLE and accepts the next pair.
- Assert rst for 1 cycle during pass p2 of 0xB7 x 0x5C:
  - After the edge: IDLE, busy=0, out_valid=0, out_r=0.
  - The next pair 0x03 x 0x05 yields 0x000F.
- Back-to-back: 10 random pairs with in_valid held high against an exact-multiplier scoreboard. Every out_r equals a*b, in order, with no drops or duplicates.
